// File: rtl/tapa_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tapa_ctrl_pkg
//   Shared definitions for the per-task launch controllers: the controller
//   state encoding and the default widths used by the task wrappers.
// ----------------------------------------------------------------------------
package tapa_ctrl_pkg;

   localparam int unsigned TAPA_ARG_W  = 64;
   localparam int unsigned TAPA_CNT_W  = 16;
   localparam int unsigned TAPA_PERF_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      RUN   = 2'b10,
      DONE  = 2'b11
   } tapa_state_e;

endpackage

// File: rtl/tapa_sat_counter.sv
// ----------------------------------------------------------------------------
// tapa_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping. Reusable by any
//   task wrapper that reports a run-length performance figure.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, counter returns to zero
//   clr_i   synchronous clear, has priority over en_i
//   en_i    count enable
//   cnt_o   current count
// ----------------------------------------------------------------------------
module tapa_sat_counter
   import tapa_ctrl_pkg::*;
#(
   parameter int unsigned W = TAPA_PERF_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tapa_task_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tapa_task_ctrl_fsm
//   Per-task responder for the global launch FSM. Accepts a launch, latches
//   the task's scalar arguments and iteration count, then drives one HLS
//   child kernel through ap_start/ap_ready/ap_done ITER times. When all
//   invocations have completed it raises is_done and holds it until the
//   global FSM acknowledges with global_fsm_ap_done.
//
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   global_fsm_ap_start   launch request (level or pulse), honoured in IDLE
//   global_fsm_ap_done    global completion, releases is_done
//   arg_in, iter_count    scalar args / invocation count, sampled at launch
//   is_done               task finished (held until global_fsm_ap_done)
//   busy                  high in every state except IDLE
//   child_ap_start        child kernel start
//   child_ap_ready        child accepted start
//   child_ap_done         child invocation finished
//   child_arg             args latched at the most recent launch
//   cycle_count           START+RUN cycles of the last launch, saturating
//   proto_err             sticky child-protocol violation flag
// ----------------------------------------------------------------------------
module tapa_task_ctrl_fsm
   import tapa_ctrl_pkg::*;
#(
   parameter int unsigned ARG_W  = TAPA_ARG_W,
   parameter int unsigned CNT_W  = TAPA_CNT_W,
   parameter int unsigned PERF_W = TAPA_PERF_W
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              global_fsm_ap_start,
   input  logic              global_fsm_ap_done,
   input  logic [ARG_W-1:0]  arg_in,
   input  logic [CNT_W-1:0]  iter_count,
   output logic              is_done,
   output logic              busy,
   output logic              child_ap_start,
   input  logic              child_ap_ready,
   input  logic              child_ap_done,
   output logic [ARG_W-1:0]  child_arg,
   output logic [PERF_W-1:0] cycle_count,
   output logic              proto_err
);

   tapa_state_e      state_q, state_d;
   logic [ARG_W-1:0] arg_q, arg_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             perr_q, perr_d;
   logic             launch;
   logic [CNT_W-1:0] done_cnt_inc;

   // done_cnt never exceeds iter_q, so this increment cannot wrap.
   assign done_cnt_inc = done_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      arg_d      = arg_q;
      iter_d     = iter_q;
      done_cnt_d = done_cnt_q;
      perr_d     = perr_q;
      launch     = 1'b0;
      case (state_q)
         IDLE: begin
            if (global_fsm_ap_start) begin
               launch     = 1'b1;
               arg_d      = arg_in;
               iter_d     = iter_count;
               done_cnt_d = '0;
               perr_d     = 1'b0;
               // A zero-iteration launch completes without touching the child.
               state_d    = (iter_count != '0) ? START : DONE;
            end
         end
         START: begin
            if (child_ap_ready) begin
               if (child_ap_done) begin
                  // Same-cycle accept and finish: relaunch back-to-back.
                  done_cnt_d = done_cnt_inc;
                  if (done_cnt_inc == iter_q) begin
                     state_d = DONE;
                  end
               end else begin
                  state_d = RUN;
               end
            end else if (child_ap_done) begin
               // Done before the start was accepted: flag and drop it.
               perr_d = 1'b1;
            end
         end
         RUN: begin
            if (child_ap_done) begin
               done_cnt_d = done_cnt_inc;
               state_d    = (done_cnt_inc == iter_q) ? DONE : START;
            end else if (child_ap_ready) begin
               // Ready without an outstanding start.
               perr_d = 1'b1;
            end
         end
         DONE: begin
            // A simultaneous start is not taken here; a held start is
            // accepted on the following IDLE cycle.
            if (global_fsm_ap_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= IDLE;
         arg_q      <= '0;
         iter_q     <= '0;
         done_cnt_q <= '0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         arg_q      <= arg_d;
         iter_q     <= iter_d;
         done_cnt_q <= done_cnt_d;
         perr_q     <= perr_d;
      end
   end

   tapa_sat_counter #(
      .W (PERF_W)
   ) u_cycle_cnt (
      .clk_i  (ap_clk),
      .rst_ni (ap_rst_n),
      .clr_i  (launch),
      .en_i   ((state_q == START) || (state_q == RUN)),
      .cnt_o  (cycle_count)
   );

   // Outputs decode from registers only.
   assign child_ap_start = (state_q == START);
   assign is_done        = (state_q == DONE);
   assign busy           = (state_q != IDLE);
   assign child_arg      = arg_q;
   assign proto_err      = perr_q;

endmodule

// File: tb/tb_tapa_task_ctrl_fsm.sv
module tb_tapa_task_ctrl_fsm;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        global_fsm_ap_start;
   logic        global_fsm_ap_done;
   logic [63:0] arg_in;
   logic [15:0] iter_count;
   logic        is_done;
   logic        busy;
   logic        child_ap_start;
   logic        child_ap_ready;
   logic        child_ap_done;
   logic [63:0] child_arg;
   logic [31:0] cycle_count;
   logic        proto_err;

   tapa_task_ctrl_fsm #(
      .ARG_W  (64),
      .CNT_W  (16),
      .PERF_W (32)
   ) dut (
      .ap_clk              (ap_clk),
      .ap_rst_n            (ap_rst_n),
      .global_fsm_ap_start (global_fsm_ap_start),
      .global_fsm_ap_done  (global_fsm_ap_done),
      .arg_in              (arg_in),
      .iter_count          (iter_count),
      .is_done             (is_done),
      .busy                (busy),
      .child_ap_start      (child_ap_start),
      .child_ap_ready      (child_ap_ready),
      .child_ap_done       (child_ap_done),
      .child_arg           (child_arg),
      .cycle_count         (cycle_count),
      .proto_err           (proto_err)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: one entry per launch expected to reach DONE.
   typedef struct {
      logic [63:0] arg;
      int          starts;
      logic [31:0] cc;
      logic        perr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mon_starts = 0;
   logic prev_busy  = 1'b0;
   logic prev_done  = 1'b0;

   always @(negedge ap_clk) begin
      if (busy && !prev_busy) mon_starts = 0;
      if (child_ap_start) mon_starts++;
      if (is_done && !prev_done) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_done", 64'(is_done), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            check("sb_child_arg",   child_arg,          mon_e.arg);
            check("sb_cycle_count", 64'(cycle_count),   64'(mon_e.cc));
            check("sb_proto_err",   64'(proto_err),     64'(mon_e.perr));
            check("sb_start_cycles", 64'(mon_starts),   64'(mon_e.starts));
         end
      end
      prev_busy = busy;
      prev_done = is_done;
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] a, input int s, input logic [31:0] c, input logic p);
      exp_t e;
      e.arg = a; e.starts = s; e.cc = c; e.perr = p;
      sb.push_back(e);
   endtask

   task automatic launch(input logic [63:0] a, input logic [15:0] n);
      arg_in = a;
      iter_count = n;
      global_fsm_ap_start = 1'b1;
      tick();
      global_fsm_ap_start = 1'b0;
   endtask

   // One child invocation starting in START: ready after rw cycles,
   // done after dw further RUN cycles.
   task automatic child_iter(input int rw, input int dw);
      repeat (rw) tick();
      child_ap_ready = 1'b1;
      tick();
      child_ap_ready = 1'b0;
      check("run_no_start", 64'(child_ap_start), 64'(0));
      repeat (dw) tick();
      child_ap_done = 1'b1;
      tick();
      child_ap_done = 1'b0;
   endtask

   task automatic gdone();
      global_fsm_ap_done = 1'b1;
      tick();
      global_fsm_ap_done = 1'b0;
      check("release_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst_n = 1'b0;
      global_fsm_ap_start = 1'b0;
      global_fsm_ap_done = 1'b0;
      arg_in = '0;
      iter_count = '0;
      child_ap_ready = 1'b0;
      child_ap_done = 1'b0;
      #12;
      check("rst_is_done", 64'(is_done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_start", 64'(child_ap_start), 64'(0));
      check("rst_arg", child_arg, 64'(0));
      check("rst_cc", 64'(cycle_count), 64'(0));
      check("rst_perr", 64'(proto_err), 64'(0));
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      tick();

      // Three back-to-back invocations, ready and done together.
      push_exp(64'h11, 3, 32'd3, 1'b0);
      child_ap_ready = 1'b1;
      child_ap_done = 1'b1;
      launch(64'h11, 16'd3);
      for (int i = 0; i < 3; i++) begin
         check("b2b_start", 64'(child_ap_start), 64'(1));
         check("b2b_not_done", 64'(is_done), 64'(0));
         tick();
      end
      child_ap_ready = 1'b0;
      child_ap_done = 1'b0;
      check("b2b_is_done", 64'(is_done), 64'(1));
      check("b2b_start_low", 64'(child_ap_start), 64'(0));
      gdone();

      // Two invocations through RUN, DONE held for 10 cycles.
      push_exp(64'h22, 4, 32'd12, 1'b0);
      launch(64'h22, 16'd2);
      check("launch_latency", 64'(child_ap_start), 64'(1));
      child_iter(1, 3);
      check("iter1_back_to_start", 64'(child_ap_start), 64'(1));
      child_iter(1, 3);
      check("iter2_is_done", 64'(is_done), 64'(1));
      global_fsm_ap_start = 1'b1;
      repeat (10) tick();
      check("done_held", 64'(is_done), 64'(1));
      check("done_ignores_start", 64'(child_arg), 64'h22);

      // Start and done together in DONE: go IDLE, then accept the held start
      // as a zero-iteration launch.
      push_exp(64'hA5, 0, 32'd0, 1'b0);
      arg_in = 64'hA5;
      iter_count = 16'd0;
      global_fsm_ap_done = 1'b1;
      tick();
      global_fsm_ap_done = 1'b0;
      check("both_to_idle", 64'(busy), 64'(0));
      tick();
      global_fsm_ap_start = 1'b0;
      check("zero_iter_done", 64'(is_done), 64'(1));
      check("zero_iter_no_start", 64'(child_ap_start), 64'(0));
      gdone();

      // Arguments frozen after launch.
      push_exp(64'hDEAD_BEEF, 1, 32'd3, 1'b0);
      launch(64'hDEAD_BEEF, 16'd1);
      child_ap_ready = 1'b1;
      tick();
      child_ap_ready = 1'b0;
      arg_in = 64'hFFFF_0000_FFFF;
      iter_count = 16'd9;
      tick();
      check("arg_frozen", child_arg, 64'hDEAD_BEEF);
      child_ap_done = 1'b1;
      tick();
      child_ap_done = 1'b0;
      gdone();
      push_exp(64'h1234, 1, 32'd2, 1'b0);
      launch(64'h1234, 16'd1);
      check("arg_relaunch", child_arg, 64'h1234);
      child_iter(0, 0);
      gdone();

      // Protocol violations: done without ready in START, ready alone in RUN.
      push_exp(64'h44, 2, 32'd4, 1'b1);
      launch(64'h44, 16'd1);
      child_ap_done = 1'b1;
      tick();
      child_ap_done = 1'b0;
      check("perr_set", 64'(proto_err), 64'(1));
      check("perr_stay_start", 64'(child_ap_start), 64'(1));
      child_ap_ready = 1'b1;
      tick();
      check("perr_run", 64'(busy & ~child_ap_start & ~is_done), 64'(1));
      tick();
      child_ap_ready = 1'b0;
      check("perr_sticky", 64'(proto_err), 64'(1));
      child_ap_done = 1'b1;
      tick();
      child_ap_done = 1'b0;
      check("perr_one_done", 64'(is_done), 64'(1));
      gdone();

      // Async reset mid-RUN, then a clean run.
      launch(64'h55, 16'd2);
      check("launch_clears_perr", 64'(proto_err), 64'(0));
      child_ap_ready = 1'b1;
      tick();
      child_ap_ready = 1'b0;
      tick();
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_start", 64'(child_ap_start), 64'(0));
      check("arst_cc", 64'(cycle_count), 64'(0));
      check("arst_arg", child_arg, 64'(0));
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      tick();
      push_exp(64'h66, 1, 32'd2, 1'b0);
      launch(64'h66, 16'd1);
      child_iter(0, 0);
      gdone();

      tick();
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
